fiber_tx_sched: RTL and testbench
=================================

# fiber_tx_sched

Two-source frame scheduler in front of the 256-bit Aurora 64B/66B TX AXI-stream, in the `fiber_clk` domain. It shares the single four-lane link between the command/frame path (source 0) and the DDC data path (source 1). Each source requests a frame of a declared beat length. The block grants one source at a time, muxes its stream onto the link, generates `tx_tlast`, inserts an inter-frame gap, and aborts cleanly if `CHANNEL_UP` drops.

## Interface
Parameters:
- `DATA_W`, 256: TX beat width (4 lanes × 64 bit).
- `LEN_W`, 16: frame length field width, in beats.
- `IFG_CYCLES`, 2: idle cycles forced between frames; 0 is legal.
- `MAX_CONSEC`, 4: maximum consecutive source-0 grants while source 1 is pending.

Ports:
- `fiber_clk` in 1: Aurora user clock; the only clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `channel_up` in 1: Aurora `CHANNEL_UP`.
- `req` in 2: per-source frame request; held high until that source's `done` pulse.
- `len0`, `len1` in LEN_W: frame length in beats; stable while `req` is high.
- `s0_tdata`, `s1_tdata` in DATA_W: source beat data.
- `s0_tvalid`, `s1_tvalid` in 1: source beat valid.
- `s_tready` out 2: per-source ready.
- `gnt` out 2: one-hot grant; 00 when idle.
- `done` out 2: 1-cycle per-source frame-complete pulse.
- `abort` out 1: 1-cycle pulse; the frame was terminated by loss of `channel_up`.
- `len_err` out 1: 1-cycle pulse; a zero-length request was rejected.
- `tx_tdata` out DATA_W, `tx_tvalid` out 1, `tx_tlast` out 1: to Aurora.
- `tx_tready` in 1: from Aurora.
- `frame_cnt` out 16: completed (non-aborted) frames; wraps at 0xFFFF→0.

## Operation
- States: IDLE, SEND, FLUSH, GAP.
- **IDLE**
  - Arbitration runs only when `channel_up` = 1.
  - Source 0 wins unless the consecutive-source-0 counter equals MAX_CONSEC and `req[1]` is high; in that case source 1 wins.
  - The counter increments on each source-0 grant and clears on any source-1 grant.
  - The winner's length is latched into `beats_left`, `gnt` is set, and the state goes to SEND.
  - If the winner's length is 0: pulse `len_err`, pulse that source's `done`, stay in IDLE. The losing source is considered next cycle.
- **SEND**
  - `tx_tdata` = granted source's data. `tx_tvalid` = granted `sN_tvalid`. `s_tready[g]` = `tx_tready`.
  - The non-granted ready is 0.
  - `tx_tlast` = `tx_tvalid` & (`beats_left` == 1).
  - A beat is accepted on `tx_tvalid` & `tx_tready`; `beats_left` decrements.
  - When the last beat is accepted: pulse `done[g]`, increment `frame_cnt`, clear `gnt`, go to GAP (or IDLE if IFG_CYCLES = 0).
- **FLUSH** (entered from SEND when `channel_up` = 0)
  - `tx_tvalid` = 0, `s_tready[g]` = 1.
  - Remaining source beats are counted down and discarded.
  - When count reaches 0: pulse `abort` and `done[g]`, go to GAP. `frame_cnt` is not incremented.
- **GAP**: counts IFG_CYCLES with all outputs idle, then returns to IDLE.
- Outputs when not in SEND: `tx_tvalid` = 0, `tx_tlast` = 0, `tx_tdata` = 0.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `req` sampled high in cycle t (IDLE, channel up) → `gnt` registered high in t+1. The first beat can transfer in t+1.
- Datapath is combinational mux, zero added latency. `beats_left`, `gnt`, and state are registered.
- `done`/`abort` assert the cycle after the final handshake. `gnt` drops in the same cycle.
- Back-to-back frame from the same source: next `gnt` no earlier than IFG_CYCLES+1 cycles after `done`.
- `channel_up` falling on the last-beat cycle: the beat is treated as accepted only if `tx_tready` was high. Otherwise FLUSH discards 1 beat.
- `rst_n` asserted mid-frame: immediate return to reset values. The source must re-request.
- `len` changes during SEND are ignored. `req` dropping during SEND is ignored; the frame completes.

## Structure
- `fiber_pkg` holds:
  - the state enum;
  - source index constants `SRC_CMD` = 0, `SRC_DDC` = 1;
  - default IFG/MAX_CONSEC localparams.
- Sub-module `fiber_tx_pick`: combinational winner selection plus the registered consecutive-grant counter.
- The top holds the FSM, the beat counter, the mux, and the statistics.

## Test plan
- `req` = 01, `len0` = 3, sources always valid, `tx_tready` = 1 → `gnt` = 01 for 3 cycles, `tx_tlast` on beat 3, `done` = 01, `frame_cnt` = 1, then 2 idle cycles.
- `tx_tready` toggling 1,0,1,0 with `len1` = 4 → exactly 4 transfers, `tx_tlast` only on the 4th, data unchanged while stalled.
- Both requesting continuously, `len0` = `len1` = 1 → grant order 0,0,0,0,1,0,0,0,0,1…
- `len0` = 0 → `len_err` pulse, `done[0]` pulse, no `tx_tvalid`; pending source 1 granted next.
- `channel_up` drops after beat 2 of 8 → `tx_tvalid` = 0, 6 beats drained, `abort` and `done` pulse, `frame_cnt` unchanged.
- `rst_n` low mid-frame → all outputs 0 asynchronously; after release, a new request is granted normally.

Source files
------------

// File: rtl/fiber_pkg.sv
// Shared types and constants for the fiber TX frame scheduler.
package fiber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Source indices on the req/gnt/done vectors
    localparam int SRC_CMD = 0;
    localparam int SRC_DDC = 1;

    localparam int DEF_IFG_CYCLES = 2;
    localparam int DEF_MAX_CONSEC = 4;

    // One-hot vector for a source index
    function automatic logic [1:0] src_onehot(input logic src);
        return src ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fiber_tx_pick.sv
// Winner selection between the command and DDC sources, with a
// consecutive-command-grant counter that hands the link to DDC when
// the command path has had MAX_CONSEC grants in a row.
module fiber_tx_pick
    import fiber_pkg::*;
#(
    parameter int MAX_CONSEC = DEF_MAX_CONSEC
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    input  logic       i_take_src,
    output logic       o_any,
    output logic       o_win
);

    logic [7:0] r_consec;
    logic       w_force_ddc;

    // Combinational winner: command wins unless its streak is exhausted and DDC waits
    always_comb begin
        w_force_ddc = (r_consec == 8'(MAX_CONSEC)) && i_req[SRC_DDC];
        o_any       = |i_req;
        if (i_req[SRC_CMD] && !w_force_ddc) begin
            o_win = 1'b0;
        end else if (i_req[SRC_DDC]) begin
            o_win = 1'b1;
        end else begin
            o_win = 1'b0;
        end
    end

    // Streak counter: saturating count of command grants, cleared by a DDC grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_consec <= 8'd0;
        end else if (i_take) begin
            if (i_take_src) begin
                r_consec <= 8'd0;
            end else if (r_consec != 8'(MAX_CONSEC)) begin
                r_consec <= r_consec + 8'd1;
            end
        end
    end

endmodule

// File: rtl/fiber_tx_sched.sv
// Two-source frame scheduler in front of the Aurora 64B/66B TX stream:
// grants one source per frame, muxes it onto the link, generates tlast,
// enforces an inter-frame gap and drains the frame if the channel drops.
module fiber_tx_sched
    import fiber_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int LEN_W      = 16,
    parameter int IFG_CYCLES = DEF_IFG_CYCLES,
    parameter int MAX_CONSEC = DEF_MAX_CONSEC
) (
    input  logic              fiber_clk,
    input  logic              rst_n,
    input  logic              channel_up,
    input  logic [1:0]        req,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s0_tvalid,
    input  logic              s1_tvalid,
    output logic [1:0]        s_tready,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              abort,
    output logic              len_err,
    output logic [DATA_W-1:0] tx_tdata,
    output logic              tx_tvalid,
    output logic              tx_tlast,
    input  logic              tx_tready,
    output logic [15:0]       frame_cnt
);

    localparam bit         NO_GAP   = (IFG_CYCLES == 0);
    localparam logic [7:0] GAP_LAST = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

    state_t           r_state;
    logic [1:0]       r_gnt;
    logic             r_src;
    logic [LEN_W-1:0] r_beats_left;
    logic [7:0]       r_gap_cnt;
    logic [1:0]       r_done;
    logic             r_abort;
    logic             r_len_err;
    logic [15:0]      r_frame_cnt;

    logic [1:0]       w_req_eff;
    logic             w_any;
    logic             w_win;
    logic [LEN_W-1:0] w_win_len;
    logic             w_take;
    logic             w_svalid;
    logic             w_accept;

    // A source whose done is pulsing still holds req this cycle; hide it so it is not re-served
    always_comb begin
        w_req_eff = req & ~r_done;
        w_win_len = w_win ? len1 : len0;
        w_take    = (r_state == ST_IDLE) && channel_up && w_any && (w_win_len != {LEN_W{1'b0}});
        w_svalid  = r_src ? s1_tvalid : s0_tvalid;
        w_accept  = (r_state == ST_SEND) && w_svalid && tx_tready;
    end

    fiber_tx_pick #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_pick (
        .i_clk      (fiber_clk),
        .i_rst_n    (rst_n),
        .i_req      (w_req_eff),
        .i_take     (w_take),
        .i_take_src (w_win),
        .o_any      (w_any),
        .o_win      (w_win)
    );

    // Main frame FSM: arbitration, beat countdown, drain on link loss, gap timing, statistics
    always_ff @(posedge fiber_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 2'b00;
            r_src        <= 1'b0;
            r_beats_left <= {LEN_W{1'b0}};
            r_gap_cnt    <= 8'd0;
            r_done       <= 2'b00;
            r_abort      <= 1'b0;
            r_len_err    <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_done    <= 2'b00;
            r_abort   <= 1'b0;
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (channel_up && w_any) begin
                        if (w_win_len == {LEN_W{1'b0}}) begin
                            r_len_err <= 1'b1;
                            r_done    <= src_onehot(w_win);
                        end else begin
                            r_gnt        <= src_onehot(w_win);
                            r_src        <= w_win;
                            r_beats_left <= w_win_len;
                            r_state      <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_accept && (r_beats_left == LEN_W'(1))) begin
                        // Last beat taken: a completed frame even if the link drops now
                        r_done      <= r_gnt;
                        r_gnt       <= 2'b00;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_gap_cnt   <= GAP_LAST;
                        if (NO_GAP) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else if (!channel_up) begin
                        r_beats_left <= r_beats_left - LEN_W'(w_accept);
                        r_state      <= ST_FLUSH;
                    end else if (w_accept) begin
                        r_beats_left <= r_beats_left - LEN_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (w_svalid) begin
                        if (r_beats_left <= LEN_W'(1)) begin
                            r_done    <= r_gnt;
                            r_abort   <= 1'b1;
                            r_gnt     <= 2'b00;
                            r_gap_cnt <= GAP_LAST;
                            if (NO_GAP) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end else begin
                            r_beats_left <= r_beats_left - LEN_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    // Zero-latency datapath mux; link side is idle outside SEND, drain accepts source beats
    always_comb begin
        tx_tdata  = {DATA_W{1'b0}};
        tx_tvalid = 1'b0;
        tx_tlast  = 1'b0;
        s_tready  = 2'b00;
        case (r_state)
            ST_SEND: begin
                tx_tdata  = r_src ? s1_tdata : s0_tdata;
                tx_tvalid = w_svalid;
                tx_tlast  = w_svalid && (r_beats_left == LEN_W'(1));
                s_tready  = r_gnt & {2{tx_tready}};
            end
            ST_FLUSH: begin
                s_tready = r_gnt;
            end
            default: begin
                s_tready = 2'b00;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign abort     = r_abort;
    assign len_err   = r_len_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fiber_tx_sched.sv
// Scoreboard bench for fiber_tx_sched: expected beats and grants are queued
// when a request is issued and consumed by a monitor on the negative edge.
module tb_fiber_tx_sched;

    localparam int DATA_W = 256;
    localparam int LEN_W  = 16;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              last;
    } beat_t;

    logic              fiber_clk = 1'b0;
    logic              rst_n;
    logic              channel_up;
    logic [1:0]        req;
    logic [LEN_W-1:0]  len0;
    logic [LEN_W-1:0]  len1;
    logic [DATA_W-1:0] s0_tdata;
    logic [DATA_W-1:0] s1_tdata;
    logic              s0_tvalid;
    logic              s1_tvalid;
    logic [1:0]        s_tready;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              abort;
    logic              len_err;
    logic [DATA_W-1:0] tx_tdata;
    logic              tx_tvalid;
    logic              tx_tlast;
    logic              tx_tready;
    logic [15:0]       frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int idx0     = 0;
    int idx1     = 0;
    int exp_idx0 = 0;
    int exp_idx1 = 0;
    int xfer_cnt = 0;

    beat_t beat_q[$];
    int    gnt_q[$];

    fiber_tx_sched #(
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .IFG_CYCLES (2),
        .MAX_CONSEC (4)
    ) dut (
        .fiber_clk  (fiber_clk),
        .rst_n      (rst_n),
        .channel_up (channel_up),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .s0_tdata   (s0_tdata),
        .s1_tdata   (s1_tdata),
        .s0_tvalid  (s0_tvalid),
        .s1_tvalid  (s1_tvalid),
        .s_tready   (s_tready),
        .gnt        (gnt),
        .done       (done),
        .abort      (abort),
        .len_err    (len_err),
        .tx_tdata   (tx_tdata),
        .tx_tvalid  (tx_tvalid),
        .tx_tlast   (tx_tlast),
        .tx_tready  (tx_tready),
        .frame_cnt  (frame_cnt)
    );

    always #5 fiber_clk = ~fiber_clk;

    function automatic logic [DATA_W-1:0] mk(input int src, input int idx);
        return {8{8'(src), 24'(idx)}};
    endfunction

    assign s0_tdata = mk(0, idx0);
    assign s1_tdata = mk(1, idx1);

    // Source models advance their beat index on every source-side handshake
    always @(posedge fiber_clk) begin
        if (s_tready[0] && s0_tvalid) idx0 <= idx0 + 1;
        if (s_tready[1] && s1_tvalid) idx1 <= idx1 + 1;
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue one frame: grant, the beats that should reach the link, and the source beats it consumes
    task automatic push_frame(input int src, input int len, input int n_seen, input int consumed);
        beat_t b;
        gnt_q.push_back(src);
        for (int k = 0; k < n_seen; k++) begin
            b.d    = mk(src, ((src == 0) ? exp_idx0 : exp_idx1) + k);
            b.last = (k == len - 1);
            beat_q.push_back(b);
        end
        if (src == 0) exp_idx0 += consumed;
        else          exp_idx1 += consumed;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge fiber_clk);
        #1;
    endtask

    task automatic wait_done(input logic [1:0] which, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge fiber_clk);
            if ((done & which) != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("done_wait", 256'(ok), 256'(1));
    endtask

    task automatic wait_gnt(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge fiber_clk);
            if (gnt != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("gnt_wait", 256'(ok), 256'(1));
    endtask

    // Monitor: compare every link transfer and every new grant with the scoreboard
    always @(negedge fiber_clk) begin
        beat_t       e;
        int          g;
        logic [1:0]  eg;
        static logic [1:0] prev_gnt = 2'b00;
        if (rst_n) begin
            if (tx_tvalid && tx_tready) begin
                xfer_cnt++;
                check_eq("beat_q_nonempty", 256'(beat_q.size() != 0), 256'(1));
                if (beat_q.size() != 0) begin
                    e = beat_q.pop_front();
                    check_eq("beat_data", tx_tdata, e.d);
                    check_eq("beat_last", 256'(tx_tlast), 256'(e.last));
                end
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                check_eq("gnt_q_nonempty", 256'(gnt_q.size() != 0), 256'(1));
                if (gnt_q.size() != 0) begin
                    g  = gnt_q.pop_front();
                    eg = (g == 1) ? 2'b10 : 2'b01;
                    check_eq("gnt_order", 256'(gnt), 256'(eg));
                end
            end
            prev_gnt = gnt;
        end else begin
            prev_gnt = 2'b00;
        end
    end

    initial begin
        bit                ok;
        bit                stalled;
        bit                vseen;
        int                cnt;
        int                x0;
        int                drained;
        logic [DATA_W-1:0] held;

        rst_n = 1'b0; channel_up = 1'b1; req = 2'b00; len0 = 16'd0; len1 = 16'd0;
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; tx_tready = 1'b1;
        held = {DATA_W{1'b0}};
        #2;
        check_eq("rst_gnt",       256'(gnt),       256'(0));
        check_eq("rst_done",      256'(done),      256'(0));
        check_eq("rst_abort",     256'(abort),     256'(0));
        check_eq("rst_len_err",   256'(len_err),   256'(0));
        check_eq("rst_tvalid",    256'(tx_tvalid), 256'(0));
        check_eq("rst_tdata",     tx_tdata,        256'(0));
        check_eq("rst_s_tready",  256'(s_tready),  256'(0));
        check_eq("rst_frame_cnt", 256'(frame_cnt), 256'(0));
        repeat (2) @(posedge fiber_clk);
        #1 rst_n = 1'b1;
        cyc(2);

        // Basic frame of 3 beats from source 0, then a back-to-back frame
        len0 = 16'd3;
        push_frame(0, 3, 3, 3);
        push_frame(0, 3, 3, 3);
        req = 2'b01;
        cnt = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge fiber_clk);
            if (done != 2'b00) begin ok = 1'b1; break; end
            if (gnt == 2'b01) cnt++;
        end
        check_eq("t1_done_seen",  256'(ok),        256'(1));
        check_eq("t1_done",       256'(done),      256'(2'b01));
        check_eq("t1_gnt_cycles", 256'(cnt),       256'(3));
        check_eq("t1_frame_cnt",  256'(frame_cnt), 256'(1));
        check_eq("t1_gnt_drop",   256'(gnt),       256'(0));
        cnt = 0; vseen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge fiber_clk);
            cnt++;
            if (gnt != 2'b00) break;
            if (tx_tvalid) vseen = 1'b1;
        end
        check_eq("t1_regrant_gap", 256'(cnt),   256'(3));
        check_eq("t1_gap_idle",    256'(vseen), 256'(0));
        wait_done(2'b01, 20);
        check_eq("t1_frame_cnt2", 256'(frame_cnt), 256'(2));
        @(posedge fiber_clk); #1 req = 2'b00;

        // Source 1, 4 beats, tx_tready toggling
        cyc(4);
        len1 = 16'd4;
        push_frame(1, 4, 4, 4);
        x0 = xfer_cnt;
        req = 2'b10;
        wait_gnt(20);
        stalled = 1'b0; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done != 2'b00) begin ok = 1'b1; break; end
            if (tx_tvalid && !tx_tready) begin
                held = tx_tdata; stalled = 1'b1;
            end else if (stalled) begin
                check_eq("t2_stall_data", tx_tdata, held);
                stalled = 1'b0;
            end
            @(posedge fiber_clk); #1 tx_tready = ~tx_tready;
            @(negedge fiber_clk);
        end
        check_eq("t2_done_seen",  256'(ok),            256'(1));
        check_eq("t2_done",       256'(done),          256'(2'b10));
        check_eq("t2_xfers",      256'(xfer_cnt - x0), 256'(4));
        check_eq("t2_frame_cnt",  256'(frame_cnt),     256'(3));
        @(posedge fiber_clk); #1 tx_tready = 1'b1; req = 2'b00;

        // Fairness: both always requesting, 1-beat frames
        cyc(4);
        len0 = 16'd1; len1 = 16'd1;
        for (int g = 0; g < 10; g++) push_frame((g % 5 == 4) ? 1 : 0, 1, 1, 1);
        req = 2'b11;
        for (int g = 0; g < 10; g++) wait_done(2'b11, 20);
        @(posedge fiber_clk); #1 req = 2'b00;
        check_eq("t3_frame_cnt", 256'(frame_cnt), 256'(13));

        // Zero-length request on source 0 with source 1 pending
        cyc(4);
        len0 = 16'd0; len1 = 16'd2;
        push_frame(1, 2, 2, 2);
        req = 2'b11;
        @(negedge fiber_clk);
        @(negedge fiber_clk);
        check_eq("t4_len_err", 256'(len_err),   256'(1));
        check_eq("t4_done0",   256'(done),      256'(2'b01));
        check_eq("t4_no_gnt",  256'(gnt),       256'(0));
        check_eq("t4_tvalid",  256'(tx_tvalid), 256'(0));
        @(posedge fiber_clk); #1 req = 2'b10;
        @(negedge fiber_clk);
        check_eq("t4_gnt1",       256'(gnt),     256'(2'b10));
        check_eq("t4_len_err_lo", 256'(len_err), 256'(0));
        wait_done(2'b10, 20);
        check_eq("t4_frame_cnt", 256'(frame_cnt), 256'(14));
        @(posedge fiber_clk); #1 req = 2'b00;

        // Channel loss after beat 2 of 8
        cyc(4);
        len0 = 16'd8;
        push_frame(0, 8, 2, 8);
        x0 = xfer_cnt;
        req = 2'b01;
        wait_gnt(20);
        @(posedge fiber_clk); #1;
        @(posedge fiber_clk); #1 channel_up = 1'b0; tx_tready = 1'b0;
        @(negedge fiber_clk);
        vseen = 1'b0; drained = 0; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge fiber_clk);
            if (done != 2'b00) begin ok = 1'b1; break; end
            if (tx_tvalid) vseen = 1'b1;
            if (s_tready[0] && s0_tvalid) drained++;
        end
        check_eq("t5_done_seen", 256'(ok),            256'(1));
        check_eq("t5_done",      256'(done),          256'(2'b01));
        check_eq("t5_abort",     256'(abort),         256'(1));
        check_eq("t5_drained",   256'(drained),       256'(6));
        check_eq("t5_no_tvalid", 256'(vseen),         256'(0));
        check_eq("t5_xfers",     256'(xfer_cnt - x0), 256'(2));
        check_eq("t5_frame_cnt", 256'(frame_cnt),     256'(14));
        @(posedge fiber_clk); #1 channel_up = 1'b1; tx_tready = 1'b1; req = 2'b00;

        // Reset in the middle of a frame, then a fresh frame
        cyc(4);
        len1 = 16'd5;
        push_frame(1, 5, 2, 2);
        req = 2'b10;
        wait_gnt(20);
        @(posedge fiber_clk); #1;
        @(posedge fiber_clk); #1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_gnt",      256'(gnt),       256'(0));
        check_eq("t6_rst_tvalid",   256'(tx_tvalid), 256'(0));
        check_eq("t6_rst_tdata",    tx_tdata,        256'(0));
        check_eq("t6_rst_s_tready", 256'(s_tready),  256'(0));
        check_eq("t6_rst_frame",    256'(frame_cnt), 256'(0));
        push_frame(1, 5, 5, 5);
        @(posedge fiber_clk); #1 rst_n = 1'b1;
        wait_done(2'b10, 30);
        check_eq("t6_frame_cnt", 256'(frame_cnt), 256'(1));
        @(posedge fiber_clk); #1 req = 2'b00;
        cyc(4);

        check_eq("beats_left_over",  256'(beat_q.size()), 256'(0));
        check_eq("grants_left_over", 256'(gnt_q.size()),  256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
